// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch slice: register index, FSM state and
// the architectural register count.
package rvcpu;

    localparam int unsigned NumArchRegs = 32;

    typedef logic [$clog2(NumArchRegs)-1:0] reg_t;

    typedef enum logic [1:0] {
        EMPTY,
        FETCH,
        FULL
    } opf_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Operand fetch bus bundle: decode and execute handshakes, register file read
// ports and the writeback snoop. master = fetch stage, slave = its environment.
interface operand_fetch_if #(
    parameter int unsigned Width = 32
);
    logic              in_valid;
    logic              in_ready;
    rvcpu::reg_t       in_rs1;
    rvcpu::reg_t       in_rs2;
    rvcpu::reg_t       in_rd;
    logic              in_rs1_used;
    logic              in_rs2_used;
    logic              in_rd_used;

    rvcpu::reg_t       rf_rs1;
    rvcpu::reg_t       rf_rs2;
    logic              rf_rs1_valid;
    logic              rf_rs2_valid;
    logic [Width-1:0]  rf_rd1;
    logic [Width-1:0]  rf_rd2;

    logic              wb_valid;
    rvcpu::reg_t       wb_rd;
    logic [Width-1:0]  wb_val;

    logic              out_valid;
    logic              out_ready;
    logic [Width-1:0]  out_op1;
    logic [Width-1:0]  out_op2;
    rvcpu::reg_t       out_rd;
    logic              out_rd_used;

    modport master (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_used, in_rs2_used, in_rd_used,
        output in_ready,
        output rf_rs1, rf_rs2, rf_rs1_valid, rf_rs2_valid,
        input  rf_rd1, rf_rd2,
        input  wb_valid, wb_rd, wb_val,
        output out_valid, out_op1, out_op2, out_rd, out_rd_used,
        input  out_ready
    );

    modport slave (
        output in_valid, in_rs1, in_rs2, in_rd, in_rs1_used, in_rs2_used, in_rd_used,
        input  in_ready,
        input  rf_rs1, rf_rs2, rf_rs1_valid, rf_rs2_valid,
        output rf_rd1, rf_rd2,
        output wb_valid, wb_rd, wb_val,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_used,
        output out_ready
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write mask for in-flight destinations with two source lookup ports.
// A same-cycle set and clear of one register leaves it pending.
module reg_scoreboard
    import rvcpu::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  reg_t                   set_idx,
    input  logic                   clr_en,
    input  reg_t                   clr_idx,
    input  reg_t                   lk1_idx,
    output logic                   lk1_hit,
    input  reg_t                   lk2_idx,
    output logic                   lk2_hit,
    output logic [NumArchRegs-1:0] pending_o
);

    logic [NumArchRegs-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        lk1_hit   = pending_q[lk1_idx];
        lk2_hit   = pending_q[lk2_idx];
        pending_o = pending_q;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard-checked issue of register file reads, one-entry
// output buffer. Define OPERAND_FETCH_BYPASS_EN for same-cycle writeback bypass.
module operand_fetch
    import rvcpu::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    operand_fetch_if.master bus
);

    opf_state_t       state_q, state_d;
    logic [Width-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
    logic [Width-1:0] op1_fetch, op2_fetch;
    reg_t             rd_q, rd_d;
    logic             rd_used_q, rd_used_d;
    logic             rd1_en_q, rd1_en_d, rd2_en_q, rd2_en_d;
`ifdef OPERAND_FETCH_BYPASS_EN
    logic             byp1_q, byp1_d, byp2_q, byp2_d;
    logic [Width-1:0] bypv1_q, bypv1_d, bypv2_q, bypv2_d;
`endif

    logic [NumArchRegs-1:0] pending;
    logic sb_hit1, sb_hit2, src1_hit, src2_hit, wb1, wb2;
    logic rs1_live, rs2_live, dst_live, stage_rd_live;
    logic hazard, accept, set_pending;

    reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (set_pending),
        .set_idx   (rd_q),
        .clr_en    (bus.wb_valid),
        .clr_idx   (bus.wb_rd),
        .lk1_idx   (bus.in_rs1),
        .lk1_hit   (sb_hit1),
        .lk2_idx   (bus.in_rs2),
        .lk2_hit   (sb_hit2),
        .pending_o (pending)
    );

    always_comb begin
        rs1_live      = bus.in_rs1_used && (bus.in_rs1 != '0);
        rs2_live      = bus.in_rs2_used && (bus.in_rs2 != '0);
        dst_live      = bus.in_rd_used && (bus.in_rd != '0);
        stage_rd_live = (state_q != EMPTY) && rd_used_q && (rd_q != '0);
        wb1           = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
        wb2           = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
        src1_hit      = sb_hit1 || (stage_rd_live && (rd_q == bus.in_rs1));
        src2_hit      = sb_hit2 || (stage_rd_live && (rd_q == bus.in_rs2));
`ifdef OPERAND_FETCH_BYPASS_EN
        src1_hit      = src1_hit && !wb1;
        src2_hit      = src2_hit && !wb2;
`else
        // RF read in the write cycle returns the stale value, so wait it out
        src1_hit      = src1_hit || wb1;
        src2_hit      = src2_hit || wb2;
`endif
        hazard = (rs1_live && src1_hit) || (rs2_live && src2_hit) ||
                 (dst_live && (pending[bus.in_rd] ||
                               (stage_rd_live && (rd_q == bus.in_rd))));
        bus.in_ready     = !reset && !flush && !hazard &&
                           ((state_q == EMPTY) || bus.out_ready);
        accept           = bus.in_valid && bus.in_ready;
        bus.rf_rs1       = bus.in_rs1;
        bus.rf_rs2       = bus.in_rs2;
        bus.rf_rs1_valid = accept && rs1_live;
        bus.rf_rs2_valid = accept && rs2_live;
    end

    always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
        op1_fetch = rd1_en_q ? (byp1_q ? bypv1_q : bus.rf_rd1) : '0;
        op2_fetch = rd2_en_q ? (byp2_q ? bypv2_q : bus.rf_rd2) : '0;
`else
        op1_fetch = rd1_en_q ? bus.rf_rd1 : '0;
        op2_fetch = rd2_en_q ? bus.rf_rd2 : '0;
`endif
        bus.out_valid   = (state_q != EMPTY);
        bus.out_op1     = (state_q == FETCH) ? op1_fetch : hold1_q;
        bus.out_op2     = (state_q == FETCH) ? op2_fetch : hold2_q;
        bus.out_rd      = rd_q;
        bus.out_rd_used = rd_used_q;
        set_pending     = bus.out_valid && bus.out_ready && rd_used_q && (rd_q != '0);
    end

    always_comb begin
        state_d   = state_q;
        hold1_d   = hold1_q;
        hold2_d   = hold2_q;
        rd_d      = rd_q;
        rd_used_d = rd_used_q;
        rd1_en_d  = rd1_en_q;
        rd2_en_d  = rd2_en_q;
`ifdef OPERAND_FETCH_BYPASS_EN
        byp1_d    = byp1_q;
        byp2_d    = byp2_q;
        bypv1_d   = bypv1_q;
        bypv2_d   = bypv2_q;
`endif
        if (state_q == FETCH) begin
            hold1_d = op1_fetch;
            hold2_d = op2_fetch;
        end
        unique case (state_q)
            EMPTY:       if (accept) state_d = FETCH;
            FETCH, FULL: state_d = bus.out_ready ? (accept ? FETCH : EMPTY) : FULL;
            default:     state_d = EMPTY;
        endcase
        if (accept) begin
            rd_d      = bus.in_rd;
            rd_used_d = bus.in_rd_used;
            rd1_en_d  = rs1_live;
            rd2_en_d  = rs2_live;
`ifdef OPERAND_FETCH_BYPASS_EN
            byp1_d    = rs1_live && wb1;
            byp2_d    = rs2_live && wb2;
            bypv1_d   = bus.wb_val;
            bypv2_d   = bus.wb_val;
`endif
        end
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            hold1_q   <= '0;
            hold2_q   <= '0;
            rd_q      <= '0;
            rd_used_q <= 1'b0;
            rd1_en_q  <= 1'b0;
            rd2_en_q  <= 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
            byp1_q    <= 1'b0;
            byp2_q    <= 1'b0;
            bypv1_q   <= '0;
            bypv2_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hold1_q   <= hold1_d;
            hold2_q   <= hold2_d;
            rd_q      <= rd_d;
            rd_used_q <= rd_used_d;
            rd1_en_q  <= rd1_en_d;
            rd2_en_q  <= rd2_en_d;
`ifdef OPERAND_FETCH_BYPASS_EN
            byp1_q    <= byp1_d;
            byp2_q    <= byp2_d;
            bypv1_q   <= bypv1_d;
            bypv2_q   <= bypv2_d;
`endif
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a register file model and an
// expected-output queue; honours OPERAND_FETCH_BYPASS_EN for stall timing.
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_used;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;

    operand_fetch_if #(.Width(32)) bus ();

    operand_fetch #(.Width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.master)
    );

    logic [31:0] mem [32];
    exp_t        expq [$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    logic        s_acc, s_rf1v, s_rf2v;
    int          waited;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read, write at the same edge (reads see old data)
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            bus.rf_rd1 <= '0;
            bus.rf_rd2 <= '0;
        end else begin
            if (bus.rf_rs1_valid) bus.rf_rd1 <= mem[bus.rf_rs1];
            if (bus.rf_rs2_valid) bus.rf_rd2 <= mem[bus.rf_rs2];
            if (bus.wb_valid && bus.wb_rd != 5'd0) mem[bus.wb_rd] <= bus.wb_val;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_op(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 32'd0;
        if (bus.wb_valid && bus.wb_rd == rs) return bus.wb_val;
        return mem[rs];
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_acc  = bus.in_valid && bus.in_ready;
        s_rf1v = bus.rf_rs1_valid;
        s_rf2v = bus.rf_rs2_valid;
        if (s_acc) begin
            e.op1     = exp_op(bus.in_rs1, bus.in_rs1_used);
            e.op2     = exp_op(bus.in_rs2, bus.in_rs2_used);
            e.rd      = bus.in_rd;
            e.rd_used = bus.in_rd_used;
            expq.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
            n_asserts++;
            assert (expq.size() > 0) else begin
                n_fail++;
                $error("FAIL out_unexpected: queue size %0d, required > 0", expq.size());
            end
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_op1", bus.out_op1, e.op1);
                chk("out_op2", bus.out_op2, e.op2);
                chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
                chk("out_rd_used", {31'd0, bus.out_rd_used}, {31'd0, e.rd_used});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic ud);
        bus.in_rs1 = rs1; bus.in_rs1_used = u1;
        bus.in_rs2 = rs2; bus.in_rs2_used = u2;
        bus.in_rd  = rd;  bus.in_rd_used  = ud;
        bus.in_valid = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic ud,
                         output int wt);
        present(rs1, u1, rs2, u2, rd, ud);
        wt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_acc) break;
            wt++;
        end
        chk("issue_accept", {31'd0, s_acc}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] val);
        bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_val = val;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd1; bus.in_rs1_used = 1'b1;
        bus.in_rs2 = 5'd0; bus.in_rs2_used = 1'b0; bus.in_rd = 5'd0; bus.in_rd_used = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_val = '0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_rf_rs1_valid", {31'd0, bus.rf_rs1_valid}, 32'd0);
        chk("rst_out_op1", bus.out_op1, 32'd0);
        chk("rst_out_op2", bus.out_op2, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("rst_out_rd_used", {31'd0, bus.out_rd_used}, 32'd0);
        reset = 1'b0; bus.in_valid = 1'b0;
        tick();

        // Preload x1/x2 and read both
        wb(5'd1, 32'h11); tick();
        wb(5'd2, 32'h22); tick();
        bus.wb_valid = 1'b0;
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, waited);
        chk("t1_wait", waited, 0);
        chk("t1_rf_rs1_valid", {31'd0, s_rf1v}, 32'd1);
        chk("t1_rf_rs2_valid", {31'd0, s_rf2v}, 32'd1);
        chk("t1_latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();

        // x0 source: no read, operand zero
        issue(5'd0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, waited);
        chk("t2_rf_rs1_valid", {31'd0, s_rf1v}, 32'd0);
        chk("t2_rf_rs2_valid", {31'd0, s_rf2v}, 32'd1);
        tick();

        // RAW on x5 released by writeback
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, waited);
        present(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick(); chk("t3_stall0", {31'd0, s_acc}, 32'd0);
        tick(); chk("t3_stall1", {31'd0, s_acc}, 32'd0);
        wb(5'd5, 32'hDEAD);
        tick();
        bus.wb_valid = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        chk("t3_accept_wb_cycle", {31'd0, s_acc}, 32'd1);
`else
        chk("t3_stall_wb_cycle", {31'd0, s_acc}, 32'd0);
        tick();
        chk("t3_accept_after_wb", {31'd0, s_acc}, 32'd1);
`endif
        bus.in_valid = 1'b0;
        tick(); tick();

        // Back-pressure: operands held, no reads while full
        bus.out_ready = 1'b0;
        issue(5'd7, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, waited);
        present(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) wb(5'd7, 32'h77);
            chk("t4_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("t4_rf_rs1_valid", {31'd0, bus.rf_rs1_valid}, 32'd0);
            chk("t4_hold_op1", bus.out_op1, 32'd0);
            chk("t4_hold_op2", bus.out_op2, 32'h11);
            tick();
            bus.wb_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        tick();
        chk("t4_accept_on_release", {31'd0, s_acc}, 32'd1);
        bus.in_valid = 1'b0;
        tick();

        // Flush while full with rd=9; x9 must not be left pending
        bus.out_ready = 1'b0;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, waited);
        tick();
        chk("t5_full_out_rd", {27'd0, bus.out_rd}, 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_out_valid_after_flush", {31'd0, bus.out_valid}, 32'd0);
        if (expq.size() > 0) void'(expq.pop_front());
        bus.out_ready = 1'b1;
        issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, waited);
        chk("t5_no_stall_x9", waited, 0);
        tick();

        // WAW on x3
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, waited);
        present(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick(); chk("t6_stall0", {31'd0, s_acc}, 32'd0);
        tick(); chk("t6_stall1", {31'd0, s_acc}, 32'd0);
        wb(5'd3, 32'h33);
        tick(); chk("t6_stall_wb_cycle", {31'd0, s_acc}, 32'd0);
        bus.wb_valid = 1'b0;
        tick(); chk("t6_accept", {31'd0, s_acc}, 32'd1);
        bus.in_valid = 1'b0;
        tick(); tick();

        chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
